// File: rtl/vai_tx_skid.sv
// Per-sub-AFU Tx skid buffer. Independent c0/c1 FIFOs drive registered downstream ports with 1-cycle bypass latency.
// Absorbs requests issued after almost-full and drains them in order once downstream almost-full clears; c2 is registered straight through.
`timescale 1ns/1ps

package vai_ccip_pkg;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

endpackage

// Generic FIFO with a combinational head. The caller never writes while full
// unless it also reads that cycle, and never reads while empty.
module vai_tx_skid_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   pClk,
  input  logic                   SoftReset_n,
  input  logic                   wrEn,
  input  logic [W-1:0]           wrDat,
  input  logic                   rdEn,
  output logic [W-1:0]           rdDat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  always_ff @(posedge pClk) begin
    if (wrEn) mem[wrPtr] <= wrDat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      if (wrEn && !rdEn)      count <= count + 1'b1;
      else if (rdEn && !wrEn) count <= count - 1'b1;
    end
  end

  assign rdDat = mem[rdPtr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  assert property (@(posedge pClk) disable iff (!SoftReset_n) !(wrEn && full && !rdEn));
  assert property (@(posedge pClk) disable iff (!SoftReset_n) !(rdEn && empty));

endmodule

// One request channel: FIFO plus a single-cycle output register, with
// empty-FIFO bypass, registered almost-full, sticky overflow and beat counter.
module vai_tx_skid_chan #(
  parameter int W             = 8,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic         pClk,
  input  logic         SoftReset_n,
  input  logic         inVld,
  input  logic [W-1:0] inDat,
  input  logic         dnAlmFull,
  output logic         outVld,
  output logic [W-1:0] outDat,
  output logic         almFull,
  output logic         errOverflow,
  output logic [31:0]  reqCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - ALMFULL_SLACK);

  logic [AW:0]  occ;
  logic [AW:0]  occNext;
  logic [W-1:0] headDat;
  logic         empty;
  logic         full;
  logic         bypass;
  logic         deq;
  logic         wrEn;
  logic         drop;

  // The output register only ever holds a request for one cycle, so it is
  // always free; the only gate on moving data out is downstream almost-full.
  assign deq    = !dnAlmFull && !empty;
  assign bypass = inVld && empty && !dnAlmFull;
  assign wrEn   = inVld && !bypass && (!full || deq);
  assign drop   = inVld && !bypass && full && !deq;

  vai_tx_skid_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) fifo (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .wrEn        (wrEn),
    .wrDat       (inDat),
    .rdEn        (deq),
    .rdDat       (headDat),
    .count       (occ),
    .empty       (empty),
    .full        (full)
  );

  always_comb begin
    occNext = occ;
    if (wrEn && !deq)      occNext = occ + 1'b1;
    else if (deq && !wrEn) occNext = occ - 1'b1;
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      outVld      <= 1'b0;
      almFull     <= 1'b1;
      errOverflow <= 1'b0;
      reqCnt      <= '0;
    end else begin
      outVld  <= bypass || deq;
      almFull <= (occNext >= THRESH);
      if (drop) errOverflow <= 1'b1;
      if (bypass || deq) reqCnt <= reqCnt + 32'd1;
    end
  end

  // Payload needs no reset; it is qualified by outVld.
  always_ff @(posedge pClk) begin
    if (bypass)   outDat <= inDat;
    else if (deq) outDat <= headDat;
  end

  assert property (@(posedge pClk) disable iff (!SoftReset_n) !(bypass && deq));

endmodule

module vai_tx_skid
  import vai_ccip_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic        pClk,
  input  logic        SoftReset_n,
  input  t_if_ccip_Tx afu_TxPort,
  output logic        afu_c0TxAlmFull,
  output logic        afu_c1TxAlmFull,
  output t_if_ccip_Tx dn_TxPort,
  input  logic        dn_c0TxAlmFull,
  input  logic        dn_c1TxAlmFull,
  output logic [1:0]  err_overflow,
  output logic [31:0] c0_req_cnt,
  output logic [31:0] c1_req_cnt
);
  localparam int C0W = $bits(t_ccip_c0_ReqMemHdr);
  localparam int C1W = $bits(t_ccip_c1_ReqMemHdr) + $bits(t_ccip_clData);

  logic                c0Vld;
  logic                c1Vld;
  logic                c2Vld;
  logic [C0W-1:0]      c0Dat;
  logic [C1W-1:0]      c1Dat;
  t_ccip_c2_RspMmioHdr c2Hdr;
  t_ccip_mmioData      c2Data;
  logic                c0Err;
  logic                c1Err;

  vai_tx_skid_chan #(
    .W             (C0W),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (ALMFULL_SLACK)
  ) c0Chan (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .inVld       (afu_TxPort.c0.valid),
    .inDat       (afu_TxPort.c0.hdr),
    .dnAlmFull   (dn_c0TxAlmFull),
    .outVld      (c0Vld),
    .outDat      (c0Dat),
    .almFull     (afu_c0TxAlmFull),
    .errOverflow (c0Err),
    .reqCnt      (c0_req_cnt)
  );

  // c1 beats carry header and data together so multi-beat writes stay ordered.
  vai_tx_skid_chan #(
    .W             (C1W),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (ALMFULL_SLACK)
  ) c1Chan (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .inVld       (afu_TxPort.c1.valid),
    .inDat       ({afu_TxPort.c1.hdr, afu_TxPort.c1.data}),
    .dnAlmFull   (dn_c1TxAlmFull),
    .outVld      (c1Vld),
    .outDat      (c1Dat),
    .almFull     (afu_c1TxAlmFull),
    .errOverflow (c1Err),
    .reqCnt      (c1_req_cnt)
  );

  // MMIO read responses are never held back by almost-full.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) c2Vld <= 1'b0;
    else              c2Vld <= afu_TxPort.c2.mmioRdValid;
  end

  always_ff @(posedge pClk) begin
    c2Hdr  <= afu_TxPort.c2.hdr;
    c2Data <= afu_TxPort.c2.data;
  end

  always_comb begin
    dn_TxPort                = '0;
    dn_TxPort.c0.valid       = c0Vld;
    dn_TxPort.c0.hdr         = c0Dat;
    dn_TxPort.c1.valid       = c1Vld;
    {dn_TxPort.c1.hdr, dn_TxPort.c1.data} = c1Dat;
    dn_TxPort.c2.mmioRdValid = c2Vld;
    dn_TxPort.c2.hdr         = c2Hdr;
    dn_TxPort.c2.data        = c2Data;
  end

  assign err_overflow = {c1Err, c0Err};

endmodule

// File: tb/tb_vai_tx_skid.sv
// Bench for vai_tx_skid: per-cycle vector table for handshake/flag timing,
// scoreboard queues for payload order, hand sequences for the multi-cycle corners.
`timescale 1ns/1ps

module tb_vai_tx_skid;
  import vai_ccip_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam int W0 = $bits(t_ccip_c0_ReqMemHdr);
  localparam int W1 = $bits(t_ccip_c1_ReqMemHdr) + $bits(t_ccip_clData);
  localparam int W2 = $bits(t_ccip_c2_RspMmioHdr) + $bits(t_ccip_mmioData);
  localparam int NV = 13;

  logic        pClk = 1'b0;
  logic        SoftReset_n;
  t_if_ccip_Tx afuTx;
  t_if_ccip_Tx dnTx;
  logic        afuAf0, afuAf1;
  logic        dnAf0, dnAf1;
  logic [1:0]  errOvf;
  logic [31:0] cnt0, cnt1;

  always #5 pClk = ~pClk;

  vai_tx_skid #(.DEPTH(16), .ALMFULL_SLACK(8)) dut (
    .pClk            (pClk),
    .SoftReset_n     (SoftReset_n),
    .afu_TxPort      (afuTx),
    .afu_c0TxAlmFull (afuAf0),
    .afu_c1TxAlmFull (afuAf1),
    .dn_TxPort       (dnTx),
    .dn_c0TxAlmFull  (dnAf0),
    .dn_c1TxAlmFull  (dnAf1),
    .err_overflow    (errOvf),
    .c0_req_cnt      (cnt0),
    .c1_req_cnt      (cnt1)
  );

  typedef struct {
    logic       v0, af0, v1, af1, v2;
    logic       eAf0, eAf1, eD0, eD1, eD2;
    logic [1:0] eErr;
  } vec_t;

  vec_t          vec[NV];
  int            tests = 0;
  int            failed = 0;
  int            expCnt0 = 0;
  int            expCnt1 = 0;
  logic [W0-1:0] q0[$];
  logic [W1-1:0] q1[$];
  logic [W2-1:0] q2[$];

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [639:0] rnd();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge pClk);
    #1;
  endtask

  // Drives one cycle of inputs; every accepted request is queued as expected output.
  task automatic drive(input logic v0, input logic af0, input logic v1, input logic af1,
                       input logic v2, input logic keep0 = 1'b1);
    logic [639:0] r;
    r = rnd();
    afuTx.c0.hdr   = r[W0-1:0];
    afuTx.c0.valid = v0;
    r = rnd();
    {afuTx.c1.hdr, afuTx.c1.data} = r[W1-1:0];
    afuTx.c1.valid = v1;
    r = rnd();
    {afuTx.c2.hdr, afuTx.c2.data} = r[W2-1:0];
    afuTx.c2.mmioRdValid = v2;
    dnAf0 = af0;
    dnAf1 = af1;
    if (v0 && keep0) q0.push_back(afuTx.c0.hdr);
    if (v1) q1.push_back({afuTx.c1.hdr, afuTx.c1.data});
    if (v2) q2.push_back({afuTx.c2.hdr, afuTx.c2.data});
  endtask

  task automatic doReset();
    afuTx       = '0;
    dnAf0       = 1'b0;
    dnAf1       = 1'b0;
    SoftReset_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    expCnt0 = 0;
    expCnt1 = 0;
    step();
    step();
    chk("rst_afu_af0", afuAf0, 1'b1);
    chk("rst_afu_af1", afuAf1, 1'b1);
    chk("rst_dn_vld", {dnTx.c0.valid, dnTx.c1.valid, dnTx.c2.mmioRdValid}, 3'b000);
    chk("rst_err", errOvf, 2'b00);
    chk("rst_cnt", {cnt1, cnt0}, 64'd0);
    SoftReset_n = 1'b1;
  endtask

  // Scoreboard: every downstream beat must match the oldest expected entry.
  always @(negedge pClk) begin
    if (SoftReset_n === 1'b1) begin
      if (dnTx.c0.valid) begin
        expCnt0++;
        chk("c0_cnt", cnt0, expCnt0);
        chk("c0_pending", q0.size() > 0, 1'b1);
        if (q0.size() > 0) chk("c0_hdr", dnTx.c0.hdr, q0.pop_front());
      end
      if (dnTx.c1.valid) begin
        expCnt1++;
        chk("c1_cnt", cnt1, expCnt1);
        chk("c1_pending", q1.size() > 0, 1'b1);
        if (q1.size() > 0) chk("c1_beat", {dnTx.c1.hdr, dnTx.c1.data}, q1.pop_front());
      end
      if (dnTx.c2.mmioRdValid) begin
        chk("c2_pending", q2.size() > 0, 1'b1);
        if (q2.size() > 0) chk("c2_rsp", {dnTx.c2.hdr, dnTx.c2.data}, q2.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  initial begin
    int n;
    //          v0 af0 v1 af1 v2   eAf0 eAf1 eD0 eD1 eD2  eErr
    vec[0]  = '{O, O,  O, O,  O,   O,   O,   O,  O,  O,   2'b00}; // first edge after reset
    vec[1]  = '{I, O,  O, O,  O,   O,   O,   I,  O,  O,   2'b00}; // c0 bypass
    vec[2]  = '{O, O,  O, O,  O,   O,   O,   O,  O,  O,   2'b00};
    vec[3]  = '{O, O,  I, I,  O,   O,   O,   O,  O,  O,   2'b00}; // c1 queued
    vec[4]  = '{O, O,  I, I,  O,   O,   O,   O,  O,  O,   2'b00};
    vec[5]  = '{O, O,  O, O,  O,   O,   O,   O,  I,  O,   2'b00}; // drain
    vec[6]  = '{O, O,  I, O,  O,   O,   O,   O,  I,  O,   2'b00}; // enq+deq, no bypass past queue
    vec[7]  = '{O, O,  O, O,  O,   O,   O,   O,  I,  O,   2'b00};
    vec[8]  = '{O, O,  O, O,  O,   O,   O,   O,  O,  O,   2'b00};
    vec[9]  = '{O, I,  O, I,  I,   O,   O,   O,  O,  I,   2'b00}; // c2 ignores almFull
    vec[10] = '{I, I,  O, I,  O,   O,   O,   O,  O,  O,   2'b00};
    vec[11] = '{O, O,  O, O,  O,   O,   O,   I,  O,  O,   2'b00};
    vec[12] = '{I, O,  I, O,  O,   O,   O,   I,  I,  O,   2'b00};

    doReset();
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].v0, vec[i].af0, vec[i].v1, vec[i].af1, vec[i].v2);
      step();
      chk($sformatf("vec%0d_afu_af0", i), afuAf0, vec[i].eAf0);
      chk($sformatf("vec%0d_afu_af1", i), afuAf1, vec[i].eAf1);
      chk($sformatf("vec%0d_dn_c0", i), dnTx.c0.valid, vec[i].eD0);
      chk($sformatf("vec%0d_dn_c1", i), dnTx.c1.valid, vec[i].eD1);
      chk($sformatf("vec%0d_dn_c2", i), dnTx.c2.mmioRdValid, vec[i].eD2);
      chk($sformatf("vec%0d_err", i), errOvf, vec[i].eErr);
    end
    drive(O, O, O, O, O);
    step();

    // Back-pressure absorb: 8 c1 writes raise almFull, then drain back-to-back.
    doReset();
    for (int i = 0; i < 8; i++) begin
      drive(O, O, I, I, O);
      step();
      chk($sformatf("absorb_af1_%0d", i), afuAf1, i == 7);
    end
    drive(O, O, O, O, O);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("absorb_dn_c1_%0d", i), dnTx.c1.valid, 1'b1);
      chk($sformatf("absorb_af1_drain_%0d", i), afuAf1, 1'b0);
    end
    step();
    chk("absorb_dn_c1_done", dnTx.c1.valid, 1'b0);

    // Overflow: 17 reads into a 16-deep FIFO, the last is dropped.
    doReset();
    for (int i = 0; i < 17; i++) begin
      drive(I, I, O, O, O, i < 16);
      step();
      chk($sformatf("ovf_err_%0d", i), errOvf, (i == 16) ? 2'b01 : 2'b00);
      chk($sformatf("ovf_af0_%0d", i), afuAf0, i >= 7);
    end
    drive(O, O, O, O, O);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n += int'(dnTx.c0.valid);
    end
    chk("ovf_emitted", n, 16);
    chk("ovf_cnt", cnt0, 32'd16);
    chk("ovf_err_sticky", errOvf, 2'b01);
    chk("ovf_af0_idle", afuAf0, 1'b0);

    // Full FIFO with a same-cycle dequeue accepts the new read.
    doReset();
    for (int i = 0; i < 16; i++) begin
      drive(I, I, O, O, O);
      step();
    end
    chk("full_err_before", errOvf, 2'b00);
    drive(I, O, O, O, O);
    step();
    chk("full_simul_dn_c0", dnTx.c0.valid, 1'b1);
    chk("full_simul_af0", afuAf0, 1'b1);
    chk("full_simul_err", errOvf, 2'b00);
    drive(O, I, O, O, O);
    step();
    chk("full_hold_dn_c0", dnTx.c0.valid, 1'b0);
    drive(O, O, O, O, O);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n += int'(dnTx.c0.valid);
    end
    chk("full_emitted", n, 16);
    chk("full_cnt", cnt0, 32'd17);
    chk("full_err_after", errOvf, 2'b00);

    // Reset during the third drained beat discards everything still buffered.
    doReset();
    for (int i = 0; i < 10; i++) begin
      drive(O, O, I, I, O);
      step();
    end
    drive(O, O, O, O, O);
    step();
    step();
    step();
    chk("mid_beat3_vld", dnTx.c1.valid, 1'b1);
    #1 SoftReset_n = 1'b0;
    #1;
    chk("mid_rst_dn_c1", dnTx.c1.valid, 1'b0);
    chk("mid_rst_af1", afuAf1, 1'b1);
    doReset();
    step();
    chk("mid_post_af1", afuAf1, 1'b0);
    chk("mid_post_cnt1", cnt1, 32'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      n += int'(dnTx.c1.valid);
    end
    chk("mid_no_stale", n, 0);

    // c2 passes through while c0/c1 are back-pressured.
    doReset();
    drive(O, I, O, I, I);
    step();
    chk("c2_vld", dnTx.c2.mmioRdValid, 1'b1);
    drive(O, I, O, I, O);
    step();
    chk("c2_vld_once", dnTx.c2.mmioRdValid, 1'b0);
    drive(O, O, O, O, O);
    step();
    step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
